// File: rtl/dm_bytelane.sv
// Byte-lane data memory: byte/half/word stores, sign/zero-extended loads, misalignment flag.
// Define DM_INIT_CLEAR_EN to compile in the post-reset clear sweep that zeroes every word.
module dm_bytelane #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [1:0]            size,
    input  logic                  uns,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  rvalid,
    output logic                  misalign,
    output logic                  busy
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << IDX_W;

    logic [31:0]      mem_q [DEPTH];
    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic             aligned;
    logic             acc;
    logic             st_we;
    logic             ld_go;
    logic             bad;
    logic [3:0]       be;
    logic [31:0]      wd;
    logic             clr_we;
    logic [IDX_W-1:0] clr_idx;

    logic [31:0]      rword_q;
    logic             ld_p_q;
    logic             mis_p_q;
    logic [1:0]       off_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic             rvalid_q;
    logic             misalign_q;
    logic [31:0]      rdata_q;
    logic [31:0]      rdata_d;
    logic [7:0]       sel_b;
    logic [15:0]      sel_h;

    assign idx = addr[ADDR_WIDTH-1:2];
    assign off = addr[1:0];

    always_comb begin
        aligned = 1'b0;
        unique case (size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~addr[0];
            2'b10:   aligned = (off == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    assign acc   = req && !busy;
    assign st_we = acc && aligned && we;
    assign ld_go = acc && aligned && !we;
    assign bad   = acc && !aligned;

    // Replicate the right-aligned store data across lanes; the enables pick the target bytes.
    always_comb begin
        be = 4'b0000;
        wd = wdata;
        unique case (size)
            2'b00: begin
                be = 4'b0001 << off;
                wd = {4{wdata[7:0]}};
            end
            2'b01: begin
                be = off[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = wdata;
            end
        endcase
    end

`ifdef DM_INIT_CLEAR_EN
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] cnt_q;
    logic [IDX_W-1:0] cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {IDX_W{1'b1}}) begin
                state_d = ST_READY;
            end
        end
    end

    always_comb begin
        busy    = (state_q == ST_CLEAR);
        clr_we  = (state_q == ST_CLEAR);
        clr_idx = cnt_q;
    end
`else
    assign busy    = 1'b0;
    assign clr_we  = 1'b0;
    assign clr_idx = '0;
`endif

    // The word is captured at acceptance, so a store in the following cycle cannot leak into it.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_idx] <= '0;
        end else if (st_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[idx][8*i +: 8] <= wd[8*i +: 8];
                end
            end
        end
        if (ld_go) begin
            rword_q <= mem_q[idx];
        end
    end

    always_comb begin
        sel_b   = rword_q[8*off_q +: 8];
        sel_h   = off_q[1] ? rword_q[31:16] : rword_q[15:0];
        rdata_d = rword_q;
        unique case (size_q)
            2'b00:   rdata_d = {{24{~uns_q & sel_b[7]}}, sel_b};
            2'b01:   rdata_d = {{16{~uns_q & sel_h[15]}}, sel_h};
            default: rdata_d = rword_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_p_q     <= 1'b0;
            mis_p_q    <= 1'b0;
            off_q      <= 2'b00;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            rvalid_q   <= 1'b0;
            misalign_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            ld_p_q     <= ld_go;
            mis_p_q    <= bad;
            rvalid_q   <= ld_p_q;
            misalign_q <= mis_p_q;
            if (ld_go) begin
                off_q  <= off;
                size_q <= size;
                uns_q  <= uns;
            end
            if (ld_p_q) begin
                rdata_q <= rdata_d;
            end
        end
    end

    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign misalign = misalign_q;

endmodule

// File: tb/tb_dm_bytelane.sv
// Directed bench for dm_bytelane at ADDR_WIDTH=5; sweep checks compile in with DM_INIT_CLEAR_EN.
module tb_dm_bytelane;

    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [1:0]    size;
    logic          uns;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          rvalid;
    logic          misalign;
    logic          busy;

    int checks;
    int failures;
    int n;

    dm_bytelane #(.ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .size     (size),
        .uns      (uns),
        .wdata    (wdata),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .misalign (misalign),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [AW-1:0] a, input logic [1:0] s,
                         input logic u, input logic [31:0] d);
        req   = 1'b1;
        we    = w;
        addr  = a;
        size  = s;
        uns   = u;
        wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0;
        we  = 1'b0;
    endtask

    task automatic store(input logic [AW-1:0] a, input logic [1:0] s, input logic [31:0] d);
        drive(1'b1, a, s, 1'b0, d);
    endtask

    task automatic load(input string tag, input logic [AW-1:0] a, input logic [1:0] s,
                        input logic u, input logic [31:0] exp);
        drive(1'b0, a, s, u, 32'h0);
        check_eq({tag, "_early"}, {30'b0, rvalid, misalign}, 32'h0);
        @(posedge clk);
        #1;
        check_eq({tag, "_rvalid"}, {31'b0, rvalid}, 32'h1);
        check_eq({tag, "_rdata"}, rdata, exp);
        check_eq({tag, "_mis"}, {31'b0, misalign}, 32'h0);
    endtask

    task automatic bad_req(input string tag, input logic w, input logic [AW-1:0] a,
                           input logic [1:0] s, input logic [31:0] d, input logic [31:0] keep);
        drive(w, a, s, 1'b0, d);
        check_eq({tag, "_early"}, {30'b0, rvalid, misalign}, 32'h0);
        @(posedge clk);
        #1;
        check_eq({tag, "_mis"}, {31'b0, misalign}, 32'h1);
        check_eq({tag, "_rvalid"}, {31'b0, rvalid}, 32'h0);
        check_eq({tag, "_rdata"}, rdata, keep);
        @(posedge clk);
        #1;
        check_eq({tag, "_mis_end"}, {31'b0, misalign}, 32'h0);
    endtask

    task automatic count_busy(input string tag);
        n = 0;
        while (busy && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq(tag, n, 32'd8);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst   = 1'b1;
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        size  = 2'b00;
        uns   = 1'b0;
        wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rdata", rdata, 32'h0);
        check_eq("rst_rvalid", {31'b0, rvalid}, 32'h0);
        check_eq("rst_mis", {31'b0, misalign}, 32'h0);
`ifdef DM_INIT_CLEAR_EN
        check_eq("rst_busy", {31'b0, busy}, 32'h1);
        // Store held throughout the sweep must be dropped.
        req   = 1'b1;
        we    = 1'b1;
        addr  = 5'h1C;
        size  = 2'b10;
        wdata = 32'hDEADBEEF;
        rst   = 1'b0;
        count_busy("sweep_len");
        req = 1'b0;
        we  = 1'b0;
        check_eq("sweep_quiet", {30'b0, rvalid, misalign}, 32'h0);
        load("clr_1c", 5'h1C, 2'b10, 1'b0, 32'h0000_0000);
`else
        check_eq("rst_busy", {31'b0, busy}, 32'h0);
        rst = 1'b0;
        #1;
        check_eq("busy_low", {31'b0, busy}, 32'h0);
`endif

        // Word store then sub-word loads; first load issued the cycle after the store.
        store(5'h10, 2'b10, 32'h80FF7F01);
        load("lb_13",  5'h13, 2'b00, 1'b0, 32'hFFFFFF80);
        load("lbu_11", 5'h11, 2'b00, 1'b1, 32'h0000007F);
        load("lh_12",  5'h12, 2'b01, 1'b0, 32'hFFFF80FF);
        load("lhu_10", 5'h10, 2'b01, 1'b1, 32'h00007F01);
        load("lbu_12", 5'h12, 2'b00, 1'b1, 32'h000000FF);
        load("lb_11",  5'h11, 2'b00, 1'b0, 32'h0000007F);
        load("lhu_12", 5'h12, 2'b01, 1'b1, 32'h000080FF);

        // Lane isolation.
        store(5'h08, 2'b10, 32'h11223344);
        store(5'h09, 2'b00, 32'hFFFFFFAA);
        load("lw_08a", 5'h08, 2'b10, 1'b0, 32'h1122AA44);
        store(5'h0A, 2'b01, 32'h0000BEEF);
        load("lw_08b", 5'h08, 2'b10, 1'b0, 32'hBEEFAA44);

        // Misalignment and illegal size.
        store(5'h04, 2'b10, 32'hCAFEF00D);
        load("lw_04", 5'h04, 2'b10, 1'b0, 32'hCAFEF00D);
        bad_req("sh_05", 1'b1, 5'h05, 2'b01, 32'h00001234, 32'hCAFEF00D);
        bad_req("lw_0a", 1'b0, 5'h0A, 2'b10, 32'h0, 32'hCAFEF00D);
        bad_req("sz11_st", 1'b1, 5'h04, 2'b11, 32'h0, 32'hCAFEF00D);
        bad_req("sz11_ld", 1'b0, 5'h04, 2'b11, 32'h0, 32'hCAFEF00D);
        load("lw_04_keep", 5'h04, 2'b10, 1'b0, 32'hCAFEF00D);
        load("lw_08_keep", 5'h08, 2'b10, 1'b0, 32'hBEEFAA44);

        // Reset with a load in flight.
        store(5'h00, 2'b10, 32'h12345678);
        load("lw_00", 5'h00, 2'b10, 1'b0, 32'h12345678);
        drive(1'b0, 5'h00, 2'b10, 1'b0, 32'h0);
        rst = 1'b1;
        #1;
        check_eq("inflt_rdata", rdata, 32'h0);
        @(posedge clk);
        #1;
        check_eq("inflt_rvalid", {31'b0, rvalid}, 32'h0);
        check_eq("inflt_rdata2", rdata, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("inflt_rvalid2", {31'b0, rvalid}, 32'h0);

`ifdef DM_INIT_CLEAR_EN
        n = 0;
        while (busy && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        // Reset mid-sweep restarts the full sweep.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("midrst_busy", {31'b0, busy}, 32'h1);
        rst = 1'b0;
        count_busy("midrst_len");
        load("clr_10", 5'h10, 2'b10, 1'b0, 32'h0000_0000);
`else
        load("post_rst_10", 5'h10, 2'b10, 1'b0, 32'h80FF7F01);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
